seq_emit_buffer: RTL and testbench

Downstream consumer of the lazy-match summary stage. It captures each one-cycle summary result (LL/ML/offset plus end-of-job info) into a FIFO and drains it to the sequence encoder over a valid/ready handshake. It also returns the next sequence head pointer to the match-engine front end, and raises a stall early enough to cover the 3-stage summary pipeline already in flight.

---
 rtl/seq_emit_buffer.sv | 161 ++++++++++++++++
 tb/tb_seq_emit_buffer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_emit_buffer.sv
// Sequence emit buffer: FIFO between the lazy-match summary stage and the sequence encoder,
// plus head-pointer feedback and early stall. Optional per-job stats: SEQ_EMIT_BUFFER_STATS_EN.

`ifndef JOB_LEN_LOG2
`define JOB_LEN_LOG2 10
`endif
`ifndef SEQ_LL_BITS
`define SEQ_LL_BITS 16
`endif
`ifndef SEQ_ML_BITS
`define SEQ_ML_BITS 16
`endif
`ifndef SEQ_OFFSET_BITS
`define SEQ_OFFSET_BITS 17
`endif

module seq_emit_buffer #(
    parameter int DEPTH       = 16,
    parameter int STALL_SLACK = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_summary_done,
    input  logic [`JOB_LEN_LOG2-1:0]      i_seq_head_ptr,
    input  logic [`SEQ_LL_BITS-1:0]       i_summary_ll,
    input  logic [`SEQ_ML_BITS-1:0]       i_summary_ml,
    input  logic [`SEQ_OFFSET_BITS-1:0]   i_summary_offset,
    input  logic                          i_summary_delim,
    input  logic                          i_summary_eoj,
    input  logic [`SEQ_ML_BITS-1:0]       i_summary_overlap_len,
    input  logic                          i_move_to_next_job,
    input  logic [`JOB_LEN_LOG2-1:0]      i_move_forward,
    output logic                          o_seq_valid,
    input  logic                          i_seq_ready,
    output logic [`SEQ_LL_BITS-1:0]       o_seq_ll,
    output logic [`SEQ_ML_BITS-1:0]       o_seq_ml,
    output logic [`SEQ_OFFSET_BITS-1:0]   o_seq_offset,
    output logic [`SEQ_ML_BITS-1:0]       o_seq_overlap_len,
    output logic                          o_seq_eoj,
    output logic                          o_seq_delim,
    output logic                          o_head_update_valid,
    output logic [`JOB_LEN_LOG2-1:0]      o_next_head_ptr,
    output logic                          o_next_job,
    output logic                          o_stall,
`ifdef SEQ_EMIT_BUFFER_STATS_EN
    output logic [15:0]                   o_job_seq_count,
    output logic [`SEQ_LL_BITS+7:0]       o_job_lit_count,
`endif
    output logic                          o_overflow
);

    localparam int AW  = $clog2(DEPTH);
    localparam int LLW = `SEQ_LL_BITS;
    localparam int MLW = `SEQ_ML_BITS;
    localparam int OFW = `SEQ_OFFSET_BITS;
    localparam int EW  = MLW + OFW + MLW + LLW + 2;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] STALL_TH = (AW+1)'(DEPTH - STALL_SLACK);

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          push;
    logic          pop;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] rd_entry;

    assign o_seq_valid = (count != '0);
    assign pop         = o_seq_valid && i_seq_ready;
    // When full, a same-cycle pop frees the slot being written.
    assign push        = i_summary_done && ((count != FULL_CNT) || pop);
    assign count_next  = count + (AW+1)'(push) - (AW+1)'(pop);

    assign wr_entry = {i_summary_overlap_len, i_summary_offset, i_summary_ml,
                       i_summary_ll, i_summary_eoj, i_summary_delim};

    // Zero-gated so stale storage never shows on the outputs while empty.
    assign rd_entry = o_seq_valid ? mem[rd_ptr] : '0;

    assign {o_seq_overlap_len, o_seq_offset, o_seq_ml,
            o_seq_ll, o_seq_eoj, o_seq_delim} = rd_entry;

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_stall    <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count   <= count_next;
            o_stall <= (count_next >= STALL_TH);
            if (i_summary_done && !push) begin
                o_overflow <= 1'b1;
            end
        end
    end

    // Feedback is independent of FIFO acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_head_update_valid <= 1'b0;
            o_next_head_ptr     <= '0;
            o_next_job          <= 1'b0;
        end else begin
            o_head_update_valid <= i_summary_done;
            if (i_summary_done) begin
                o_next_job      <= i_move_to_next_job;
                o_next_head_ptr <= i_move_to_next_job ? '0
                                                      : i_seq_head_ptr + i_move_forward;
            end
        end
    end

`ifdef SEQ_EMIT_BUFFER_STATS_EN
    logic              stats_clear;
    logic [15:0]       seq_base;
    logic [LLW+7:0]    lit_base;
    logic [LLW+8:0]    lit_sum;

    // A push landing in the clear cycle belongs to the new job, so it counts from zero.
    always_comb begin
        seq_base = stats_clear ? '0 : o_job_seq_count;
        lit_base = stats_clear ? '0 : o_job_lit_count;
        lit_sum  = {1'b0, lit_base} + (LLW+9)'(i_summary_ll);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stats_clear     <= 1'b0;
            o_job_seq_count <= '0;
            o_job_lit_count <= '0;
        end else begin
            stats_clear <= push && i_summary_eoj;
            if (push) begin
                o_job_seq_count <= (seq_base == 16'hFFFF) ? seq_base : seq_base + 16'd1;
                o_job_lit_count <= lit_sum[LLW+8] ? '1 : lit_sum[LLW+7:0];
            end else if (stats_clear) begin
                o_job_seq_count <= '0;
                o_job_lit_count <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_seq_emit_buffer.sv
// Directed self-checking bench for seq_emit_buffer (DEPTH=16, STALL_SLACK=4, JOB_LEN=1024).
// Stats checks are compiled in when SEQ_EMIT_BUFFER_STATS_EN is defined.

`ifndef JOB_LEN_LOG2
`define JOB_LEN_LOG2 10
`endif
`ifndef SEQ_LL_BITS
`define SEQ_LL_BITS 16
`endif
`ifndef SEQ_ML_BITS
`define SEQ_ML_BITS 16
`endif
`ifndef SEQ_OFFSET_BITS
`define SEQ_OFFSET_BITS 17
`endif

module tb_seq_emit_buffer;

    localparam int JLW = `JOB_LEN_LOG2;
    localparam int LLW = `SEQ_LL_BITS;
    localparam int MLW = `SEQ_ML_BITS;
    localparam int OFW = `SEQ_OFFSET_BITS;

    logic           clk = 1'b0;
    logic           rst;
    logic           i_summary_done;
    logic [JLW-1:0] i_seq_head_ptr;
    logic [LLW-1:0] i_summary_ll;
    logic [MLW-1:0] i_summary_ml;
    logic [OFW-1:0] i_summary_offset;
    logic           i_summary_delim;
    logic           i_summary_eoj;
    logic [MLW-1:0] i_summary_overlap_len;
    logic           i_move_to_next_job;
    logic [JLW-1:0] i_move_forward;
    logic           o_seq_valid;
    logic           i_seq_ready;
    logic [LLW-1:0] o_seq_ll;
    logic [MLW-1:0] o_seq_ml;
    logic [OFW-1:0] o_seq_offset;
    logic [MLW-1:0] o_seq_overlap_len;
    logic           o_seq_eoj;
    logic           o_seq_delim;
    logic           o_head_update_valid;
    logic [JLW-1:0] o_next_head_ptr;
    logic           o_next_job;
    logic           o_stall;
    logic           o_overflow;
`ifdef SEQ_EMIT_BUFFER_STATS_EN
    logic [15:0]    o_job_seq_count;
    logic [LLW+7:0] o_job_lit_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    seq_emit_buffer #(.DEPTH(16), .STALL_SLACK(4)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .i_summary_done        (i_summary_done),
        .i_seq_head_ptr        (i_seq_head_ptr),
        .i_summary_ll          (i_summary_ll),
        .i_summary_ml          (i_summary_ml),
        .i_summary_offset      (i_summary_offset),
        .i_summary_delim       (i_summary_delim),
        .i_summary_eoj         (i_summary_eoj),
        .i_summary_overlap_len (i_summary_overlap_len),
        .i_move_to_next_job    (i_move_to_next_job),
        .i_move_forward        (i_move_forward),
        .o_seq_valid           (o_seq_valid),
        .i_seq_ready           (i_seq_ready),
        .o_seq_ll              (o_seq_ll),
        .o_seq_ml              (o_seq_ml),
        .o_seq_offset          (o_seq_offset),
        .o_seq_overlap_len     (o_seq_overlap_len),
        .o_seq_eoj             (o_seq_eoj),
        .o_seq_delim           (o_seq_delim),
        .o_head_update_valid   (o_head_update_valid),
        .o_next_head_ptr       (o_next_head_ptr),
        .o_next_job            (o_next_job),
        .o_stall               (o_stall),
`ifdef SEQ_EMIT_BUFFER_STATS_EN
        .o_job_seq_count       (o_job_seq_count),
        .o_job_lit_count       (o_job_lit_count),
`endif
        .o_overflow            (o_overflow)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_summary(input int ll, input int ml, input int off, input int ovl,
                               input logic eoj, input logic delim, input int head,
                               input int fwd, input logic next_job);
        i_summary_ll          = LLW'(ll);
        i_summary_ml          = MLW'(ml);
        i_summary_offset      = OFW'(off);
        i_summary_overlap_len = MLW'(ovl);
        i_summary_eoj         = eoj;
        i_summary_delim       = delim;
        i_seq_head_ptr        = JLW'(head);
        i_move_forward        = JLW'(fwd);
        i_move_to_next_job    = next_job;
    endtask

    initial begin
        rst            = 1'b1;
        i_summary_done = 1'b0;
        i_seq_ready    = 1'b0;
        set_summary(0, 0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check_val("rst_valid", 32'(o_seq_valid), 0);
        check_val("rst_huv", 32'(o_head_update_valid), 0);
        check_val("rst_head", 32'(o_next_head_ptr), 0);
        check_val("rst_next_job", 32'(o_next_job), 0);
        check_val("rst_stall", 32'(o_stall), 0);
        check_val("rst_overflow", 32'(o_overflow), 0);
        check_val("rst_ll", 32'(o_seq_ll), 0);

        // Single sequence
        i_seq_ready = 1'b1;
        set_summary(5, 12, 300, 3, 1'b0, 1'b0, 10, 17, 1'b0);
        i_summary_done = 1'b1;
        tick();
        i_summary_done = 1'b0;
        check_val("single_valid", 32'(o_seq_valid), 1);
        check_val("single_ll", 32'(o_seq_ll), 5);
        check_val("single_ml", 32'(o_seq_ml), 12);
        check_val("single_off", 32'(o_seq_offset), 300);
        check_val("single_ovl", 32'(o_seq_overlap_len), 3);
        check_val("single_huv", 32'(o_head_update_valid), 1);
        check_val("single_head", 32'(o_next_head_ptr), 27);
        check_val("single_next_job", 32'(o_next_job), 0);
        tick();
        check_val("single_valid_gone", 32'(o_seq_valid), 0);
        check_val("single_huv_gone", 32'(o_head_update_valid), 0);

        // Fill and stall
        i_seq_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            set_summary(i + 1, i + 100, i * 7, 0, 1'b0, 1'b0, 0, 1, 1'b0);
            i_summary_done = 1'b1;
            tick();
            if (i == 10) check_val("fill_stall_11", 32'(o_stall), 0);
        end
        i_summary_done = 1'b0;
        check_val("fill_stall_12", 32'(o_stall), 1);
        check_val("fill_head_ll", 32'(o_seq_ll), 1);
        i_seq_ready = 1'b1;
        tick();
        i_seq_ready = 1'b0;
        check_val("fill_stall_drop", 32'(o_stall), 0);
        i_seq_ready = 1'b1;
        for (int i = 1; i < 12; i++) begin
            check_val("fill_order_ll", 32'(o_seq_ll), 32'(i + 1));
            check_val("fill_order_ml", 32'(o_seq_ml), 32'(i + 100));
            tick();
        end
        check_val("fill_empty", 32'(o_seq_valid), 0);

        // Overflow
        i_seq_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            set_summary(50 + i, 1, i, 0, 1'b0, 1'b0, 0, 1, 1'b0);
            i_summary_done = 1'b1;
            tick();
        end
        i_summary_done = 1'b0;
        check_val("ovf_flag", 32'(o_overflow), 1);
        check_val("ovf_stall", 32'(o_stall), 1);
        check_val("ovf_head_ll", 32'(o_seq_ll), 50);
        set_summary(99, 2, 9, 0, 1'b0, 1'b0, 0, 1, 1'b0);
        i_summary_done = 1'b1;
        i_seq_ready    = 1'b1;
        tick();
        i_summary_done = 1'b0;
        i_seq_ready    = 1'b0;
        check_val("ovf_sticky", 32'(o_overflow), 1);
        check_val("ovf_full_pp_head", 32'(o_seq_ll), 51);
        i_seq_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_val("ovf_drain_ll", 32'(o_seq_ll), (i < 15) ? 32'(51 + i) : 32'd99);
            tick();
        end
        check_val("ovf_drain_empty", 32'(o_seq_valid), 0);
        check_val("ovf_sticky_after", 32'(o_overflow), 1);

        // End of job after a reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("eoj_rst_overflow", 32'(o_overflow), 0);
        i_seq_ready = 1'b0;
        set_summary(40, 0, 0, 0, 1'b1, 1'b1, 500, 3, 1'b1);
        i_summary_done = 1'b1;
        tick();
        i_summary_done = 1'b0;
        check_val("eoj_head", 32'(o_next_head_ptr), 0);
        check_val("eoj_next_job", 32'(o_next_job), 1);
        check_val("eoj_huv", 32'(o_head_update_valid), 1);
        check_val("eoj_valid", 32'(o_seq_valid), 1);
        check_val("eoj_eoj", 32'(o_seq_eoj), 1);
        check_val("eoj_delim", 32'(o_seq_delim), 1);
        check_val("eoj_ml", 32'(o_seq_ml), 0);
        check_val("eoj_ll", 32'(o_seq_ll), 40);
`ifdef SEQ_EMIT_BUFFER_STATS_EN
        check_val("stats_seq", 32'(o_job_seq_count), 1);
        check_val("stats_lit", 32'(o_job_lit_count), 40);
`endif
        i_seq_ready = 1'b1;
        tick();
`ifdef SEQ_EMIT_BUFFER_STATS_EN
        check_val("stats_seq_clr", 32'(o_job_seq_count), 0);
        check_val("stats_lit_clr", 32'(o_job_lit_count), 0);
`endif
        check_val("eoj_popped", 32'(o_seq_valid), 0);

        // Head wrap, then reset mid-burst
        i_seq_ready = 1'b0;
        set_summary(7, 4, 11, 0, 1'b0, 1'b0, 1020, 10, 1'b0);
        i_summary_done = 1'b1;
        tick();
        check_val("wrap_head", 32'(o_next_head_ptr), 6);
        check_val("wrap_next_job", 32'(o_next_job), 0);
        for (int i = 0; i < 4; i++) begin
            set_summary(i, 4, 11, 0, 1'b0, 1'b0, 0, 1, 1'b0);
            tick();
        end
        check_val("burst_valid", 32'(o_seq_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        i_summary_done = 1'b0;
        check_val("midrst_valid", 32'(o_seq_valid), 0);
        check_val("midrst_stall", 32'(o_stall), 0);
        check_val("midrst_overflow", 32'(o_overflow), 0);
        check_val("midrst_huv", 32'(o_head_update_valid), 0);
        check_val("midrst_ll", 32'(o_seq_ll), 0);
        tick();
        check_val("midrst_done_ignored", 32'(o_seq_valid), 0);
        check_val("midrst_huv_ignored", 32'(o_head_update_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
